dm_responder: RTL
=================

Name: dm_responder

Overview:
Data-memory responder for the pipelined CPU's load/store port. It is the target end of the CPU's mem_w / Addr_out / Data_out / DMType / Data_in interface. It accepts one request at a time through a req/ready handshake and inserts a configurable number of wait states. It performs byte, halfword and word stores using byte lanes, and returns load data right-aligned and sign- or zero-extended per DMType. Misaligned or out-of-range accesses are flagged with err instead of being performed.

Parameters:
DEPTH_WORDS, 128, number of 32-bit words stored; legal word index is 0..DEPTH_WORDS-1.
WAIT_CYCLES, 1, wait states inserted between request accept and the access/response; range 0..15.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req  in  1  request valid from the CPU MEM stage.
mem_w  in  1  1 = store, 0 = load.
addr  in  32  byte address.
din  in  32  store data; the byte or halfword is taken from the low bits.
DMType  in  3  access size/sign code.
dout  out  32  load data; valid while ready=1.
ready  out  1  one-cycle response pulse, one per accepted request.
err  out  1  valid with ready; 1 = access rejected.
busy  out  1  high in WAIT and RESP states.
dbg_addr  in  5  word index for the debug peek (low bits of the index).
dbg_data  out  32  combinational read of word dbg_addr, for the bench only.

Behaviour:
- DMType codes: dm_word=000, dm_halfword=001, dm_halfword_unsigned=010, dm_byte=011, dm_byte_unsigned=100. Codes 101 to 111 are illegal and return err.
- FSM states: IDLE, WAIT, RESP. State, counter and captured request are held in registers.
- IDLE, req=1: capture mem_w, addr, din and DMType. Go to WAIT with cnt=WAIT_CYCLES-1, or go straight to RESP if WAIT_CYCLES=0.
- WAIT: if cnt=0, go to RESP; otherwise decrement cnt. Inputs are ignored while in WAIT.
- The access is performed on the edge that enters RESP: the store commits, and dout/err are registered on that same edge.
- RESP lasts exactly one cycle with ready=1. If req=1 during RESP, the new request is captured (back-to-back). Otherwise go to IDLE.
- Latency: ready is high in the cycle after edge number WAIT_CYCLES+1, counting the accept edge as edge 1. Back-to-back throughput is one request per WAIT_CYCLES+1 cycles.
- Error conditions:
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - addr[31:2] ≥ DEPTH_WORDS;
  - illegal DMType.
- On error: err=1, dout=0, memory unchanged.
- Store steering:
  - byte: din[7:0] is written to lane addr[1:0];
  - halfword: din[15:0] is written to lanes {addr[1],0} and {addr[1],1};
  - word: all four lanes are written.
  - Other lanes keep their contents.
- Load extraction:
  - the selected byte or halfword is right-aligned in dout;
  - signed codes sign-extend, unsigned codes zero-extend;
  - word loads return the full word.
- Store responses: dout=0 and err indicates the rejection status.
- Reset values: state=IDLE, cnt=0, ready=0, err=0, dout=0, busy=0. Memory array contents are not reset.
- Reset asserted mid-request (in WAIT) aborts the request: no store is committed and no ready pulse is produced.
- A store already committed on the RESP-entry edge is not undone by a reset that arrives later.
- dbg_data reflects the array contents immediately after the committing edge.

Decomposition:
- DMType codes: reuse the dm_* defines in ctrl_encode_def.v. Add the state encodings (dmr_IDLE, dmr_WAIT, dmr_RESP) to the same shared file.
- One sub-module: dm_lane_align. It is purely combinational and handles:
  - store byte-enable and write-data steering;
  - load lane extraction and extension;
  - the misalignment / illegal-type error term.
- The FSM, counter and array live in dm_responder.

Test Plan (WAIT_CYCLES=1, DEPTH_WORDS=128):
1. sw addr 0x10, din 0xDEADBEEF, then lw 0x10 -> ready exactly 2 cycles after each accept, err=0, dout=0xDEADBEEF, dbg_data[4]=0xDEADBEEF.
2. sb addr 0x13, din 0x000000A5 -> lw 0x10 returns 0xA5ADBEEF; lb 0x13 returns 0xFFFFFFA5; lbu 0x13 returns 0x000000A5.
3. sh addr 0x12, din 0x00008001 -> lh 0x12 returns 0xFFFF8001; lhu 0x12 returns 0x00008001; lw 0x10 returns 0x8001BEEF.
4. lw 0x11 -> ready with err=1, dout=0. sw 0x12, din 0x12345678 -> err=1 and word 4 is unchanged. DMType=111 -> err=1. addr 0x200 -> err=1.
5. req held high for 4 lw requests -> ready pulses on every 2nd cycle with no gaps and the correct data each time; busy stays high throughout.
6. sw 0x20, din 0x11111111, then reset pulsed during WAIT -> no ready pulse, all outputs 0, state IDLE; a following lw 0x20 returns the value from before the sw.

Source files
------------

// File: rtl/dm_responder_pkg.sv
// Shared encodings for the data-memory responder: DMType access codes and FSM states.
package dm_responder_pkg;

    localparam logic [2:0] dm_word              = 3'b000;
    localparam logic [2:0] dm_halfword          = 3'b001;
    localparam logic [2:0] dm_halfword_unsigned = 3'b010;
    localparam logic [2:0] dm_byte              = 3'b011;
    localparam logic [2:0] dm_byte_unsigned     = 3'b100;

    typedef enum logic [1:0] {
        dmr_IDLE = 2'd0,
        dmr_WAIT = 2'd1,
        dmr_RESP = 2'd2
    } dmr_state_t;

endpackage

// File: rtl/dm_responder_lane_align.sv
// Combinational byte-lane steering for stores, lane extraction/extension for loads,
// and the misalignment / illegal-type error term.
module dm_lane_align
    import dm_responder_pkg::*;
(
    input  logic [1:0]  byte_off,
    input  logic [2:0]  dm_type,
    input  logic [31:0] din,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic        align_err
);

    logic signed [15:0] half_s;
    logic signed [7:0]  byte_s;

    always_comb begin
        be        = 4'b0000;
        wdata     = '0;
        ldata     = '0;
        align_err = 1'b0;
        half_s    = byte_off[1] ? rdata[31:16] : rdata[15:0];
        byte_s    = rdata[{byte_off, 3'b000} +: 8];
        case (dm_type)
            dm_word: begin
                align_err = (byte_off != 2'b00);
                be        = 4'b1111;
                wdata     = din;
                ldata     = rdata;
            end
            dm_halfword, dm_halfword_unsigned: begin
                align_err = byte_off[0];
                be        = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{din[15:0]}};
                ldata     = (dm_type == dm_halfword) ? 32'(half_s) : {16'b0, half_s};
            end
            dm_byte, dm_byte_unsigned: begin
                be        = 4'b0001 << byte_off;
                wdata     = {4{din[7:0]}};
                ldata     = (dm_type == dm_byte) ? 32'(byte_s) : {24'b0, byte_s};
            end
            default: align_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: req/ready handshake with WAIT_CYCLES wait states, byte-lane
// stores, extended loads, and err on misaligned / out-of-range / illegal accesses.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [2:0]  DMType,
    output logic [31:0] dout,
    output logic        ready,
    output logic        err,
    output logic        busy,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmr_state_t  state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH_WORDS];

    logic        cap_mem_w;
    logic [31:0] cap_addr;
    logic [31:0] cap_din;
    logic [2:0]  cap_type;

    logic        accept, enter_resp;
    logic        acc_mem_w;
    logic [31:0] acc_addr, acc_din;
    logic [2:0]  acc_type;
    logic [IDX_W-1:0] acc_idx;
    logic        range_err, align_err, acc_err;
    logic [3:0]  be;
    logic [31:0] wdata, ldata, rdata;
    logic [31:0] dbg_full;

    assign accept     = req && (state == dmr_IDLE || state == dmr_RESP);
    // With no wait states the access happens on the accept edge, so it must use the live request.
    assign enter_resp = (WAIT_CYCLES == 0) ? accept : (state == dmr_WAIT && cnt == 4'd0);
    assign acc_mem_w  = (WAIT_CYCLES == 0) ? mem_w  : cap_mem_w;
    assign acc_addr   = (WAIT_CYCLES == 0) ? addr   : cap_addr;
    assign acc_din    = (WAIT_CYCLES == 0) ? din    : cap_din;
    assign acc_type   = (WAIT_CYCLES == 0) ? DMType : cap_type;

    assign acc_idx   = acc_addr[IDX_W+1:2];
    assign range_err = ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign rdata     = range_err ? 32'h0 : mem[acc_idx];
    assign acc_err   = range_err | align_err;

    dm_lane_align u_align (
        .byte_off  (acc_addr[1:0]),
        .dm_type   (acc_type),
        .din       (acc_din),
        .rdata     (rdata),
        .be        (be),
        .wdata     (wdata),
        .ldata     (ldata),
        .align_err (align_err)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_mem_w <= mem_w;
            cap_addr  <= addr;
            cap_din   <= din;
            cap_type  <= DMType;
        end
    end

    always_ff @(posedge clk) begin
        if (enter_resp && acc_mem_w && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[acc_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= dmr_IDLE;
            cnt   <= 4'd0;
            ready <= 1'b0;
            err   <= 1'b0;
            dout  <= '0;
            busy  <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                dmr_IDLE, dmr_RESP: begin
                    if (req) begin
                        state <= (WAIT_CYCLES == 0) ? dmr_RESP : dmr_WAIT;
                        cnt   <= CNT_INIT;
                        busy  <= 1'b1;
                    end else begin
                        state <= dmr_IDLE;
                        busy  <= 1'b0;
                    end
                end
                dmr_WAIT: begin
                    busy <= 1'b1;
                    if (cnt == 4'd0) state <= dmr_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                default: begin
                    state <= dmr_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (enter_resp) begin
                ready <= 1'b1;
                err   <= acc_err;
                dout  <= (acc_err || acc_mem_w) ? 32'h0 : ldata;
            end
        end
    end

    always_comb begin
        dbg_full = {27'b0, dbg_addr};
        dbg_data = (dbg_full < 32'(DEPTH_WORDS)) ? mem[dbg_full[IDX_W-1:0]] : 32'h0;
    end

endmodule
